traffic_light_monitor: RTL and testbench

Passive safety checker that consumes the four 3-bit light buses driven by `traffic_control`. It is the reader side of the controller's light-output interface. Each cycle it checks light encoding, mutual exclusion, phase sequence, yellow dwell time and overall progress. The first violation is latched as a sticky fault with a code and a direction, and held until software clears it.

---
 rtl/traffic_pkg.sv | 39 +++
 rtl/light_track.sv | 63 ++++++
 rtl/traffic_light_monitor.sv | 156 +++++++++++++++
 tb/tb_traffic_light_monitor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light encodings, direction indices and fault codes for the traffic controller and its monitor.
// Pure declarations and helpers, no latency.
// No flow control.
package traffic_pkg;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  localparam int NUM_DIRS = 4;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [2:0] {
    FLT_NONE     = 3'd0,
    FLT_ENC      = 3'd1,
    FLT_CONFLICT = 3'd2,
    FLT_SEQ      = 3'd3,
    FLT_SHORT_Y  = 3'd4,
    FLT_LONG_Y   = 3'd5,
    FLT_STALL    = 3'd6
  } fault_code_e;

  // True for the three one-hot light values.
  function automatic logic light_is_legal(input logic [2:0] v);
    return (v == LIGHT_R) || (v == LIGHT_Y) || (v == LIGHT_G);
  endfunction

  // True for the only permitted light changes: G->Y, Y->R, R->G.
  function automatic logic light_step_ok(input logic [2:0] prev, input logic [2:0] cur);
    return ((prev == LIGHT_G) && (cur == LIGHT_Y)) ||
           ((prev == LIGHT_Y) && (cur == LIGHT_R)) ||
           ((prev == LIGHT_R) && (cur == LIGHT_G));
  endfunction

endpackage

// File: rtl/light_track.sv
// Per-direction tracker: remembers last light, dwell count and baseline validity; flags local violations.
// Flags are combinational on the current sample against registered history (consumed by the top's latch).
// Passive observer, never stalls.
module light_track
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 2,
  parameter int MAX_YELLOW = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [2:0] i_light,
  output logic       o_enc_err,
  output logic       o_seq_err,
  output logic       o_short_y,
  output logic       o_long_y
);

  localparam logic [CNT_W-1:0] MIN_Y_CNT  = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] LONG_Y_CNT = CNT_W'(MAX_YELLOW + 1);

  logic [2:0]       r_prev;
  logic [CNT_W-1:0] r_dwell;
  logic             r_prev_valid;

  logic             w_changed;
  logic [CNT_W-1:0] w_dwell_nxt;

  // Dwell restarts at 1 on a change, otherwise counts up and sticks at all-ones.
  always_comb begin
    w_changed = (i_light != r_prev);
    if (w_changed) begin
      w_dwell_nxt = CNT_W'(1);
    end else if (&r_dwell) begin
      w_dwell_nxt = r_dwell;
    end else begin
      w_dwell_nxt = r_dwell + CNT_W'(1);
    end
  end

  // History update; an illegal sample is never trusted as the next baseline.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_prev       <= 3'b000;
      r_dwell      <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_prev       <= i_light;
      r_dwell      <= w_dwell_nxt;
      r_prev_valid <= light_is_legal(i_light);
    end
  end

  // Local violation flags; r_dwell is the completed dwell of the value being left.
  always_comb begin
    o_enc_err = !light_is_legal(i_light);
    o_seq_err = r_prev_valid && w_changed && !light_step_ok(r_prev, i_light);
    o_short_y = r_prev_valid && (r_prev == LIGHT_Y) && w_changed && (r_dwell < MIN_Y_CNT);
    o_long_y  = (i_light == LIGHT_Y) && (w_dwell_nxt >= LONG_Y_CNT);
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor for four light buses: encoding, exclusion, sequence, yellow dwell and progress checks.
// One cycle from sampled violation to registered fault outputs.
// Passive observer; first violation is held sticky until clr_fault.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW  = 2,
  parameter int MAX_YELLOW  = 4,
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [2:0] n_lights,
  input  logic [2:0] s_lights,
  input  logic [2:0] e_lights,
  input  logic [2:0] w_lights,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir
);

  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(STALL_LIMIT);

  logic [2:0]          w_light [NUM_DIRS];
  logic [NUM_DIRS-1:0] w_enc;
  logic [NUM_DIRS-1:0] w_seq;
  logic [NUM_DIRS-1:0] w_short_y;
  logic [NUM_DIRS-1:0] w_long_y;
  logic [NUM_DIRS-1:0] w_non_red;
  logic [NUM_DIRS-1:0] w_green;

  logic [CNT_W-1:0]    r_stall;
  logic [CNT_W-1:0]    w_stall_nxt;
  logic                w_stall;
  logic [1:0]          w_first_nr;
  fault_code_e         w_code;
  logic [1:0]          w_dir;

  logic                r_fault;
  fault_code_e         r_code;
  logic [1:0]          r_dir;

  assign w_light[0] = n_lights;
  assign w_light[1] = s_lights;
  assign w_light[2] = e_lights;
  assign w_light[3] = w_lights;

  for (genvar g = 0; g < NUM_DIRS; g++) begin : g_dir
    light_track #(
      .MIN_YELLOW (MIN_YELLOW),
      .MAX_YELLOW (MAX_YELLOW),
      .CNT_W      (CNT_W)
    ) u_track (
      .clk       (clk),
      .rst_a     (rst_a),
      .i_light   (w_light[g]),
      .o_enc_err (w_enc[g]),
      .o_seq_err (w_seq[g]),
      .o_short_y (w_short_y[g]),
      .o_long_y  (w_long_y[g])
    );
    assign w_non_red[g] = (w_light[g] != LIGHT_R);
    assign w_green[g]   = (w_light[g] == LIGHT_G);
  end

  // No-green counter: cleared by any green or by a fault clear, saturating otherwise.
  always_comb begin
    if ((|w_green) || clr_fault) begin
      w_stall_nxt = '0;
    end else if (&r_stall) begin
      w_stall_nxt = r_stall;
    end else begin
      w_stall_nxt = r_stall + CNT_W'(1);
    end
    w_stall = (w_stall_nxt >= STALL_CNT);
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_stall <= '0;
    end else begin
      r_stall <= w_stall_nxt;
    end
  end

  // Lowest-index non-red direction, reported for conflicts.
  always_comb begin
    w_first_nr = 2'd0;
    for (int d = NUM_DIRS - 1; d >= 0; d--) begin
      if (w_non_red[d]) w_first_nr = 2'(d);
    end
  end

  // Priority encoder: written weakest-first so the lowest code and lowest direction overwrite last.
  always_comb begin
    w_code = FLT_NONE;
    w_dir  = 2'd0;
    if (w_stall) begin
      w_code = FLT_STALL;
      w_dir  = DIR_N;
    end
    for (int d = NUM_DIRS - 1; d >= 0; d--) begin
      if (w_long_y[d]) begin
        w_code = FLT_LONG_Y;
        w_dir  = 2'(d);
      end
    end
    for (int d = NUM_DIRS - 1; d >= 0; d--) begin
      if (w_short_y[d]) begin
        w_code = FLT_SHORT_Y;
        w_dir  = 2'(d);
      end
    end
    for (int d = NUM_DIRS - 1; d >= 0; d--) begin
      if (w_seq[d]) begin
        w_code = FLT_SEQ;
        w_dir  = 2'(d);
      end
    end
    if ($countones(w_non_red) > 1) begin
      w_code = FLT_CONFLICT;
      w_dir  = w_first_nr;
    end
    for (int d = NUM_DIRS - 1; d >= 0; d--) begin
      if (w_enc[d]) begin
        w_code = FLT_ENC;
        w_dir  = 2'(d);
      end
    end
  end

  // Sticky fault latch; a violation coinciding with a clear is latched rather than dropped.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_fault <= 1'b0;
      r_code  <= FLT_NONE;
      r_dir   <= 2'd0;
    end else if ((w_code != FLT_NONE) && (!r_fault || clr_fault)) begin
      r_fault <= 1'b1;
      r_code  <= w_code;
      r_dir   <= w_dir;
    end else if (clr_fault) begin
      r_fault <= 1'b0;
      r_code  <= FLT_NONE;
      r_dir   <= 2'd0;
    end
  end

  assign fault      = r_fault;
  assign fault_code = r_code;
  assign fault_dir  = r_dir;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: vector table, directed corner sequences, randomized traffic vs a history model.
// Outputs sampled 1 ns after each rising edge.
// Inputs driven on the falling edge.
module tb_traffic_light_monitor;

  localparam int MIN_Y   = 2;
  localparam int MAX_Y   = 4;
  localparam int STALL_L = 64;
  localparam int CAP     = 255;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic [2:0] n_lights = R, s_lights = R, e_lights = R, w_lights = R;
  logic       clr_fault = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;
  logic [5:0] dut_out;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .MIN_YELLOW  (MIN_Y),
    .MAX_YELLOW  (MAX_Y),
    .STALL_LIMIT (STALL_L),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst_a      (rst_a),
    .n_lights   (n_lights),
    .s_lights   (s_lights),
    .e_lights   (e_lights),
    .w_lights   (w_lights),
    .clr_fault  (clr_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_dir  (fault_dir)
  );

  assign dut_out = {fault, fault_code, fault_dir};

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [5:0] ex(input bit f, input int code, input int dir);
    return {f, 3'(code), 2'(dir)};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got fault=%0b code=%0d dir=%0d, want fault=%0b code=%0d dir=%0d",
                  name, act[5], act[4:2], act[1:0], exp[5], exp[4:2], exp[1:0]);
  endtask

  // ---------------- reference model: full per-direction history ----------------
  bit [2:0]   hist [4][$];
  bit         ng_hist[$];   // 1 = cycle with no green and no clear
  logic [5:0] model_out = 6'd0;

  function automatic bit legal(input bit [2:0] v);
    return v == R || v == Y || v == G;
  endfunction

  task automatic model_step(input bit rs, input bit [2:0] vn, vs, ve, vw, input bit c);
    bit [2:0] v [4];
    bit enc[4], seq[4], sy[4], ly[4];
    bit anyg, has, pvld, stepok;
    bit [2:0] cur, prev;
    int run, prun, nonred, first_nr, srun, code, dir;
    if (rs) begin
      for (int d = 0; d < 4; d++) hist[d].delete();
      ng_hist.delete();
      model_out = 6'd0;
      return;
    end
    v[0] = vn; v[1] = vs; v[2] = ve; v[3] = vw;
    anyg = 0; nonred = 0; first_nr = -1;
    for (int d = 0; d < 4; d++) begin
      cur  = v[d];
      has  = hist[d].size() > 0;
      prev = has ? hist[d][$] : 3'b000;
      pvld = has && legal(prev);
      run = 1;
      for (int k = hist[d].size() - 1; k >= 0 && hist[d][k] == cur && run < CAP; k--) run++;
      prun = 0;
      for (int k = hist[d].size() - 1; k >= 0 && hist[d][k] == prev && prun < CAP; k--) prun++;
      stepok = (prev == G && cur == Y) || (prev == Y && cur == R) || (prev == R && cur == G);
      enc[d] = !legal(cur);
      seq[d] = pvld && cur != prev && !stepok;
      sy[d]  = pvld && prev == Y && cur != Y && prun < MIN_Y;
      ly[d]  = cur == Y && run >= MAX_Y + 1;
      if (cur == G) anyg = 1;
      if (cur != R) begin
        nonred++;
        if (first_nr < 0) first_nr = d;
      end
    end
    srun = 0;
    if (!(anyg || c)) begin
      srun = 1;
      for (int k = ng_hist.size() - 1; k >= 0 && ng_hist[k] && srun < CAP; k--) srun++;
    end
    code = 0; dir = 0;
    for (int d = 0; d < 4; d++) if (code == 0 && enc[d]) begin code = 1; dir = d; end
    if (code == 0 && nonred > 1) begin code = 2; dir = first_nr; end
    for (int d = 0; d < 4; d++) if (code == 0 && seq[d]) begin code = 3; dir = d; end
    for (int d = 0; d < 4; d++) if (code == 0 && sy[d])  begin code = 4; dir = d; end
    for (int d = 0; d < 4; d++) if (code == 0 && ly[d])  begin code = 5; dir = d; end
    if (code == 0 && srun >= STALL_L) begin code = 6; dir = 0; end
    if (code != 0 && (!model_out[5] || c)) model_out = ex(1, code, dir);
    else if (c) model_out = 6'd0;
    for (int d = 0; d < 4; d++) begin
      hist[d].push_back(v[d]);
      if (hist[d].size() > 300) void'(hist[d].pop_front());
    end
    ng_hist.push_back(!anyg && !c);
    if (ng_hist.size() > 300) void'(ng_hist.pop_front());
  endtask

  // ---------------- drive / sample helpers ----------------
  task automatic drive(input bit rs, input logic [2:0] n, s, e, w, input bit c);
    @(negedge clk);
    rst_a = !rs; n_lights = n; s_lights = s; e_lights = e; w_lights = w; clr_fault = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(!rst_a, n_lights, s_lights, e_lights, w_lights, clr_fault);
  endtask

  typedef struct {
    bit         rs;
    logic [2:0] n, s, e, w;
    bit         c;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit rs, input logic [2:0] n, s, e, w, input bit c, input logic [5:0] exp);
    vec_t t;
    t.rs = rs; t.n = n; t.s = s; t.e = e; t.w = w; t.c = c; t.exp = exp;
    return t;
  endfunction

  logic [2:0] lv [4];
  logic [2:0] sv [4];
  int act, left;
  bit rrs, rc;

  initial begin
    // reset state before any clock
    #1;
    check("reset_state", dut_out, 6'd0);

    //            rs  N       S  E  W        clr  expected
    tbl.push_back(mk(1, R,      R, R, R,      0, ex(0,0,0)));
    tbl.push_back(mk(0, G,      R, R, R,      0, ex(0,0,0)));
    tbl.push_back(mk(0, G,      R, G, R,      0, ex(1,2,0)));  // conflict N/E
    tbl.push_back(mk(0, G,      R, G, 3'b011, 0, ex(1,2,0)));  // later illegal W ignored
    tbl.push_back(mk(0, G,      R, R, R,      1, ex(1,3,2)));  // clear races E G->R
    tbl.push_back(mk(0, G,      R, R, R,      1, ex(0,0,0)));
    tbl.push_back(mk(0, R,      R, R, R,      0, ex(1,3,0)));  // N G->R
    tbl.push_back(mk(0, R,      R, R, R,      1, ex(0,0,0)));
    tbl.push_back(mk(0, R,      G, R, R,      0, ex(0,0,0)));
    tbl.push_back(mk(0, R,      Y, R, R,      0, ex(0,0,0)));
    tbl.push_back(mk(0, R,      R, R, R,      0, ex(1,4,1)));  // S yellow for 1 cycle
    tbl.push_back(mk(0, R,      R, R, R,      1, ex(0,0,0)));
    tbl.push_back(mk(0, R,      R, G, R,      0, ex(0,0,0)));
    tbl.push_back(mk(0, R,      R, Y, R,      0, ex(0,0,0)));
    tbl.push_back(mk(0, R,      R, Y, R,      0, ex(0,0,0)));
    tbl.push_back(mk(0, R,      R, Y, R,      0, ex(0,0,0)));
    tbl.push_back(mk(0, R,      R, Y, R,      0, ex(0,0,0)));  // dwell 4, still legal
    tbl.push_back(mk(0, R,      R, Y, R,      0, ex(1,5,2)));  // dwell 5
    tbl.push_back(mk(0, R,      R, R, R,      1, ex(0,0,0)));  // long yellow exit is not short
    tbl.push_back(mk(1, R,      R, R, R,      0, ex(0,0,0)));
    tbl.push_back(mk(0, Y,      R, R, R,      0, ex(0,0,0)));  // no baseline after reset
    tbl.push_back(mk(0, Y,      R, R, R,      0, ex(0,0,0)));
    tbl.push_back(mk(0, R,      R, R, R,      0, ex(0,0,0)));  // yellow dwell exactly MIN
    tbl.push_back(mk(0, R,      R, R, 3'b000, 0, ex(1,1,3)));
    tbl.push_back(mk(0, G,      R, R, 3'b110, 0, ex(1,1,3)));
    tbl.push_back(mk(0, R,      R, R, R,      1, ex(1,3,0)));  // W illegal baseline skipped, N G->R
    tbl.push_back(mk(0, R,      R, R, R,      1, ex(0,0,0)));

    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].n, tbl[i].s, tbl[i].e, tbl[i].w, tbl[i].c);
      tick();
      check($sformatf("vec%0d", i), dut_out, tbl[i].exp);
    end

    // legal cycle: N G(5) Y(3) R, then S green for 200 cycles
    drive(1, R, R, R, R, 0); tick();
    for (int i = 0; i < 5; i++) begin drive(0, G, R, R, R, 0); tick(); check("legal_ng", dut_out, 6'd0); end
    for (int i = 0; i < 3; i++) begin drive(0, Y, R, R, R, 0); tick(); check("legal_ny", dut_out, 6'd0); end
    drive(0, R, R, R, R, 0); tick(); check("legal_nr", dut_out, 6'd0);
    for (int i = 0; i < 200; i++) begin drive(0, R, G, R, R, 0); tick(); check("legal_sg", dut_out, 6'd0); end

    // stall: 63 red cycles are fine, the 64th faults
    drive(1, R, R, R, R, 0); tick();
    for (int i = 0; i < 63; i++) begin drive(0, R, R, R, R, 0); tick(); end
    check("stall_63", dut_out, 6'd0);
    drive(0, R, R, R, R, 0); tick();
    check("stall_64", dut_out, ex(1,6,0));
    drive(0, R, R, R, 3'b000, 1); tick();
    check("clr_race_enc", dut_out, ex(1,1,3));

    // async reset mid-cycle while a fault is held, then first sample N=Y
    #2;
    rst_a = 1'b0;
    n_lights = Y; s_lights = R; e_lights = R; w_lights = R; clr_fault = 1'b0;
    model_step(1, R, R, R, R, 0);
    #1;
    check("async_reset", dut_out, 6'd0);
    #14;
    rst_a = 1'b1;
    tick();
    check("post_reset_y", dut_out, 6'd0);
    drive(0, Y, R, R, R, 0); tick(); check("post_reset_y2", dut_out, 6'd0);
    drive(0, R, R, R, R, 0); tick(); check("post_reset_r", dut_out, 6'd0);

    // randomized traffic against the history model
    drive(1, R, R, R, R, 0); tick();
    for (int d = 0; d < 4; d++) lv[d] = R;
    act = 0; left = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (left == 0) begin
        if (lv[act] == G) begin
          lv[act] = Y; left = $urandom_range(0, 5);
        end else if (lv[act] == Y) begin
          lv[act] = R; act = $urandom_range(0, 3);
          left = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 80) : $urandom_range(0, 2);
        end else begin
          lv[act] = G; left = $urandom_range(0, 7);
        end
      end else begin
        left--;
      end
      sv = lv;
      if ($urandom_range(0, 99) < 4) sv[$urandom_range(0, 3)] = 3'($urandom_range(0, 7));
      rrs = ($urandom_range(0, 499) == 0);
      rc  = ($urandom_range(0, 99) < 6);
      drive(rrs, sv[0], sv[1], sv[2], sv[3], rc);
      tick();
      check("random", dut_out, model_out);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
